types_static: RTL and testbench

//   Two-slot event counter with one shared ("static") total counter.

---
 rtl/types_static_pkg.sv | 18 +
 rtl/types_static_cnt.sv | 33 +++
 rtl/types_static.sv | 68 ++++++
 tb/tb_types_static.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/types_static_pkg.sv
// Shared types and increment helper for the types_static counter slice.
// Define TYPES_STATIC_SAT_EN to make every counter saturate at CNT_MAX instead of wrapping.
package types_static_pkg;

    typedef int cnt_t;

    localparam cnt_t CNT_MAX = 32'sh7FFF_FFFF;

    function automatic cnt_t cnt_inc(cnt_t v);
`ifdef TYPES_STATIC_SAT_EN
        return (v == CNT_MAX) ? v : v + 32'sd1;
`else
        // 32-bit two's complement: CNT_MAX + 1 wraps to the most negative value
        return v + 32'sd1;
`endif
    endfunction

endpackage

// File: rtl/types_static_cnt.sv
// Single event counter with synchronous active-high reset to INIT.
// Wrap or saturate behaviour comes from cnt_inc (TYPES_STATIC_SAT_EN).
module types_static_cnt
    import types_static_pkg::*;
#(
    parameter cnt_t INIT = 32'sd0
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    output cnt_t q
);

    cnt_t q_q, q_d;

    always_comb begin
        q_d = q_q;
        if (inc) begin
            q_d = cnt_inc(q_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= INIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/types_static.sv
// Two-slot event counter with a shared total; k shows the addressed slot after this edge.
// Overflow is wrap-around unless TYPES_STATIC_SAT_EN is defined (saturate at CNT_MAX).
module types_static
    import types_static_pkg::*;
#(
    parameter cnt_t I_INIT = 32'sd7,
    parameter cnt_t K_INIT = 32'sd5
) (
    input  logic clk,
    input  logic rst,
    input  logic addr,
    input  logic data,
    output cnt_t i,
    output cnt_t k
);

    cnt_t slot0_q, slot1_q, total_q;
    cnt_t sel_q, sel_d;
    cnt_t k_q;

    types_static_cnt #(
        .INIT (K_INIT)
    ) u_slot0 (
        .clk (clk),
        .rst (rst),
        .inc (data && !addr),
        .q   (slot0_q)
    );

    types_static_cnt #(
        .INIT (K_INIT)
    ) u_slot1 (
        .clk (clk),
        .rst (rst),
        .inc (data && addr),
        .q   (slot1_q)
    );

    types_static_cnt #(
        .INIT (I_INIT)
    ) u_total (
        .clk (clk),
        .rst (rst),
        .inc (data),
        .q   (total_q)
    );

    // Mirror the addressed slot's next value so k includes this edge's increment
    always_comb begin
        sel_q = addr ? slot1_q : slot0_q;
        sel_d = sel_q;
        if (data) begin
            sel_d = cnt_inc(sel_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            k_q <= K_INIT;
        end else begin
            k_q <= sel_d;
        end
    end

    assign i = total_q;
    assign k = k_q;

endmodule

// File: tb/tb_types_static.sv
// Bench for types_static: directed vector table, near-max boundary run and a
// randomized run against an array-based reference model.
module tb_types_static;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, addr, data;
    int   i, k;
    logic rst2, addr2, data2;
    int   i2, k2;

    types_static dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .data (data),
        .i    (i),
        .k    (k)
    );

    types_static #(
        .I_INIT (32'sh7FFF_FFFE),
        .K_INIT (32'sh7FFF_FFFE)
    ) dut_max (
        .clk  (clk),
        .rst  (rst2),
        .addr (addr2),
        .data (data2),
        .i    (i2),
        .k    (k2)
    );

    int checks   = 0;
    int failures = 0;
    bit sva_en   = 1'b0;

    // Reference model: plain counts per slot plus a total
    int m_cnt[2];
    int m_i, m_k;

    function automatic int m_inc(int v);
`ifdef TYPES_STATIC_SAT_EN
        if (v == 32'sh7FFF_FFFF) return v;
`endif
        return v + 1;
    endfunction

    function automatic void model_step(logic r, logic a, logic d);
        if (r) begin
            m_cnt[0] = 5;
            m_cnt[1] = 5;
            m_i      = 7;
            m_k      = 5;
        end else begin
            if (d) begin
                m_cnt[a] = m_inc(m_cnt[a]);
                m_i      = m_inc(m_i);
            end
            m_k = m_cnt[a];
        end
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic rst;
        logic addr;
        logic data;
        int   exp_i;
        int   exp_k;
    } vec_t;

    vec_t vecs[11];

`ifndef TYPES_STATIC_SAT_EN
    a_i_step: assert property (@(posedge clk) disable iff (!sva_en)
        !$past(rst) |-> (i == $past(i) + int'($past(data))))
        else $display("FAIL sva_i_step actual=%0d", i);
`endif

    initial begin
        rst = 1'b1; addr = 1'b0; data = 1'b0;
        rst2 = 1'b1; addr2 = 1'b0; data2 = 1'b0;

        vecs[0]  = '{1'b1, 1'b0, 1'b0, 7, 5};    // reset
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8, 6};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 9, 7};
        vecs[3]  = '{1'b0, 1'b0, 1'b1, 10, 8};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 11, 6};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 11, 8};   // reselect only
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 11, 6};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 11, 8};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 7, 5};    // rst beats increment
        vecs[9]  = '{1'b0, 1'b1, 1'b1, 8, 6};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 8, 5};    // slot0 untouched by slot1 traffic

        for (int n = 0; n < 11; n++) begin
            rst  = vecs[n].rst;
            addr = vecs[n].addr;
            data = vecs[n].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_i", n), i, vecs[n].exp_i);
            check($sformatf("vec%0d_k", n), k, vecs[n].exp_k);
        end

        // Near-max boundary on the second instance (rst2 held high so far)
        check("max_rst_i", i2, 32'sh7FFF_FFFE);
        check("max_rst_k", k2, 32'sh7FFF_FFFE);
        rst2  = 1'b0;
        data2 = 1'b1;
        @(posedge clk);
        #1;
        check("max_e1_i", i2, 32'sh7FFF_FFFF);
        check("max_e1_k", k2, 32'sh7FFF_FFFF);
        @(posedge clk);
        #1;
`ifdef TYPES_STATIC_SAT_EN
        check("max_e2_i", i2, 32'sh7FFF_FFFF);
        check("max_e2_k", k2, 32'sh7FFF_FFFF);
`else
        check("max_e2_i", i2, 32'sh8000_0000);
        check("max_e2_k", k2, 32'sh8000_0000);
`endif
        data2 = 1'b0;
        addr2 = 1'b1;
        @(posedge clk);
        #1;
        check("max_sel1_k", k2, 32'sh7FFF_FFFE);

        // Randomized run against the model
        rst  = 1'b1;
        addr = 1'b0;
        data = 1'b0;
        model_step(rst, addr, data);
        @(posedge clk);
        #1;
        check("rnd_rst_i", i, m_i);
        check("rnd_rst_k", k, m_k);
        sva_en = 1'b1;

        for (int n = 0; n < 1000; n++) begin
            rst  = ($urandom_range(0, 49) == 0);
            addr = 1'($urandom_range(0, 1));
            data = 1'($urandom_range(0, 1));
            model_step(rst, addr, data);
            @(posedge clk);
            #1;
            check("rnd_i", i, m_i);
            check("rnd_k", k, m_k);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
